// File: rtl/fpu_ctrl_pkg.sv
// Shared encodings, constants and the latency-select helper for the FPU issue sequencer.
package fpu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_SQRT = 3'd4
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Bit positions inside resp_flags = {invalid, divzero, bypassed}
    localparam int FLAG_BYPASS  = 0;
    localparam int FLAG_DIVZERO = 1;
    localparam int FLAG_INVALID = 2;

    localparam logic [2:0] FLG_BYPASS  = 3'(1 << FLAG_BYPASS);
    localparam logic [2:0] FLG_DIVZERO = 3'(1 << FLAG_DIVZERO);
    localparam logic [2:0] FLG_INVALID = 3'(1 << FLAG_INVALID);

    // Counter preload for an op: the hold latency minus one, so EXEC ends when cnt hits 0.
    function automatic logic [3:0] lat_cnt_init(input logic [2:0] op,
                                                input int add_lat, input int mul_lat,
                                                input int div_lat, input int sqrt_lat);
        int lat;
        case (op)
            OP_ADD, OP_SUB: lat = add_lat;
            OP_MUL:         lat = mul_lat;
            OP_DIV:         lat = div_lat;
            OP_SQRT:        lat = sqrt_lat;
            default:        lat = 1;
        endcase
        return 4'(lat - 1);
    endfunction

endpackage

// File: rtl/fpu_op_sequencer_special_detect.sv
// Combinational classifier for operands the datapath does not handle; b is the
// effective second operand (sign already flipped for sub).
module fpu_special_detect
    import fpu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        hit,
    output logic [31:0] result,
    output logic [2:0]  flags
);

    logic sa, sb, a_zero, b_zero, a_spec, b_spec;

    assign sa     = a[31];
    assign sb     = b[31];
    assign a_zero = (a[30:23] == 8'h00);
    assign b_zero = (b[30:23] == 8'h00);
    assign a_spec = (a[30:23] == 8'hFF);
    assign b_spec = (b[30:23] == 8'hFF);

    // First-match classification; denormals fall into the zero class.
    always_comb begin
        hit    = 1'b0;
        result = 32'h0;
        flags  = FLG_BYPASS;
        case (op)
            OP_ADD, OP_SUB: begin
                hit = 1'b1;
                if (a_spec || b_spec) begin
                    result = QNAN;
                    flags  = FLG_INVALID;
                end else if (a_zero && b_zero) result = {sa & sb, 31'b0};
                else if (a_zero)               result = b;
                else if (b_zero)               result = a;
                else if ((sa != sb) && (a[30:0] == b[30:0])) result = 32'h0;
                else                           hit = 1'b0;
            end
            OP_MUL: begin
                hit = 1'b1;
                if (a_spec || b_spec) begin
                    result = QNAN;
                    flags  = FLG_INVALID;
                end else if (a_zero || b_zero) result = {sa ^ sb, 31'b0};
                else                           hit = 1'b0;
            end
            OP_DIV: begin
                hit = 1'b1;
                if (a_spec || b_spec || (a_zero && b_zero)) begin
                    result = QNAN;
                    flags  = FLG_INVALID;
                end else if (b_zero) begin
                    result = {sa ^ sb, 8'hFF, 23'b0};
                    flags  = FLG_DIVZERO | FLG_BYPASS;
                end else if (a_zero) result = {sa ^ sb, 31'b0};
                else                 hit = 1'b0;
            end
            OP_SQRT: begin
                hit = 1'b1;
                if (a_spec) begin
                    result = QNAN;
                    flags  = FLG_INVALID;
                end else if (a_zero) result = a;
                else if (sa) begin
                    result = QNAN;
                    flags  = FLG_INVALID;
                end else hit = 1'b0;
            end
            default: begin
                hit    = 1'b1;
                result = QNAN;
                flags  = FLG_INVALID;
            end
        endcase
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Multicycle issue controller: holds operands on the shared FPU inputs for the op
// latency, captures the unit result, and resolves special operands locally.
module fpu_op_sequencer
    import fpu_ctrl_pkg::*;
#(
    parameter int ADD_LAT  = 1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 6,
    parameter int SQRT_LAT = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic [31:0] add_res,
    input  logic [31:0] mul_res,
    input  logic [31:0] div_res,
    input  logic [31:0] sqrt_res,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic [2:0]  resp_flags,
    output logic        busy
);

    // The hold counter is 4 bits, so each latency must fit in 1..16.
    if (ADD_LAT < 1 || ADD_LAT > 16 || MUL_LAT < 1 || MUL_LAT > 16 ||
        DIV_LAT < 1 || DIV_LAT > 16 || SQRT_LAT < 1 || SQRT_LAT > 16) begin : g_lat_check
        $error("fpu_op_sequencer: latency parameters must be within 1..16");
    end

    seq_state_e  state, state_nxt;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] b_eff;
    logic [31:0] unit_res;
    logic        accept;
    logic        byp_hit;
    logic [31:0] byp_res;
    logic [2:0]  byp_flags;

    assign req_ready  = (state == ST_IDLE) & ~flush & ~rst;
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

    // Effective second operand: sub becomes add of the negated b, sqrt has no b.
    always_comb begin
        b_eff = req_b;
        case (req_op)
            OP_SUB:  b_eff = {~req_b[31], req_b[30:0]};
            OP_SQRT: b_eff = 32'h0;
            default: b_eff = req_b;
        endcase
    end

    // Select the result of the unit that the latched op is using.
    always_comb begin
        unit_res = add_res;
        case (op_q)
            OP_MUL:  unit_res = mul_res;
            OP_DIV:  unit_res = div_res;
            OP_SQRT: unit_res = sqrt_res;
            default: unit_res = add_res;
        endcase
    end

    fpu_special_detect u_special (
        .op     (req_op),
        .a      (req_a),
        .b      (b_eff),
        .hit    (byp_hit),
        .result (byp_res),
        .flags  (byp_flags)
    );

    // Next-state logic; flush abandons EXEC/DONE without a response.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = byp_hit ? ST_DONE : ST_EXEC;
            ST_EXEC: begin
                if (flush)            state_nxt = ST_IDLE;
                else if (cnt == 4'd0) state_nxt = ST_DONE;
            end
            ST_DONE: if (flush || resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Operand, counter and response registers; operands move only at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 4'd0;
            op_q       <= 3'd0;
            fpu_a      <= 32'h0;
            fpu_b      <= 32'h0;
            resp_data  <= 32'h0;
            resp_rd    <= 5'd0;
            resp_flags <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= req_op;
                        resp_rd <= req_rd;
                        fpu_a   <= req_a;
                        fpu_b   <= b_eff;
                        if (byp_hit) begin
                            resp_data  <= byp_res;
                            resp_flags <= byp_flags;
                        end else begin
                            cnt <= lat_cnt_init(req_op, ADD_LAT, MUL_LAT, DIV_LAT, SQRT_LAT);
                        end
                    end
                end
                ST_EXEC: begin
                    if (!flush) begin
                        if (cnt == 4'd0) begin
                            resp_data  <= unit_res;
                            resp_flags <= 3'd0;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: vector table plus handwritten
// backpressure, flush and reset sequences, with a queue-based scoreboard.
module tb_fpu_op_sequencer;

    logic        clk, rst, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [2:0]  req_op, resp_flags;
    logic [31:0] req_a, req_b, fpu_a, fpu_b;
    logic [31:0] add_res, mul_res, div_res, sqrt_res, resp_data;
    logic [4:0]  req_rd, resp_rd;

    fpu_op_sequencer #(.ADD_LAT(1), .MUL_LAT(2), .DIV_LAT(6), .SQRT_LAT(12)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .fpu_a(fpu_a), .fpu_b(fpu_b),
        .add_res(add_res), .mul_res(mul_res), .div_res(div_res), .sqrt_res(sqrt_res),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_flags(resp_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic [2:0]  exp_flags;
        logic [31:0] exp_fpu_b;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  flags;
        logic [4:0]  rd;
    } exp_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];
    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    logic seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op, push its expectation, wait for the response, optionally hold
    // resp_ready low for 'hold' cycles, then pop and compare at the handshake.
    task automatic do_op(input vec_t v, input logic [4:0] rd, input int hold);
        exp_t        e;
        int          cyc;
        logic        held, stable;
        logic [31:0] d0;
        logic [4:0]  r0;
        logic [2:0]  f0;
        @(negedge clk);
        req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b; req_rd = rd;
        #1 check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        sb_q.push_back('{v.exp_data, v.exp_flags, rd});
        @(negedge clk);
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_rd = 5'(~rd);
        check("fpu_b", fpu_b, v.exp_fpu_b);
        cyc  = 1;
        held = 1'b1;
        while (!resp_valid && cyc < 40) begin
            if (fpu_a !== v.a) held = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(v.exp_lat));
        check("fpu_a_held", 32'(held), 32'd1);
        e = sb_q.pop_front();
        if (resp_valid) begin
            d0 = resp_data; r0 = resp_rd; f0 = resp_flags; stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== d0 ||
                    resp_rd !== r0 || resp_flags !== f0) stable = 1'b0;
            end
            if (hold > 0) check("hold_stable", 32'(stable), 32'd1);
            check("resp_data", resp_data, e.data);
            check("resp_flags", 32'(resp_flags), 32'(e.flags));
            check("resp_rd", 32'(resp_rd), 32'(e.rd));
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            check("req_ready_after_resp", 32'(req_ready), 32'd1);
        end
    endtask

    // Start a div 6/2 and return at the negedge of cycle 1 (cnt = 5).
    task automatic start_div(input logic [4:0] rd);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd3; req_a = 32'h40C00000; req_b = 32'h40000000; req_rd = rd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic watch_no_resp(input string name);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 3'd0; req_a = 32'h0; req_b = 32'h0; req_rd = 5'd0;
        add_res = 32'h40400000; mul_res = 32'h40C00000;
        div_res = 32'h40400001; sqrt_res = 32'h40000000;

        //          op     a             b             exp_data      flg   fpu_b         lat
        vecs[0]  = '{3'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 3'd0, 32'h40000000, 2};
        vecs[1]  = '{3'd1, 32'h40400000, 32'h40400000, 32'h00000000, 3'd1, 32'hC0400000, 1};
        vecs[2]  = '{3'd3, 32'h3F800000, 32'h80000000, 32'hFF800000, 3'd3, 32'h80000000, 1};
        vecs[3]  = '{3'd3, 32'h00000000, 32'h00000000, 32'h7FC00000, 3'd4, 32'h00000000, 1};
        vecs[4]  = '{3'd4, 32'hC0800000, 32'h12345678, 32'h7FC00000, 3'd4, 32'h00000000, 1};
        vecs[5]  = '{3'd4, 32'h40800000, 32'h3F800000, 32'h40000000, 3'd0, 32'h00000000, 13};
        vecs[6]  = '{3'd2, 32'h40000000, 32'h40400000, 32'h40C00000, 3'd0, 32'h40400000, 3};
        vecs[7]  = '{3'd2, 32'h80000000, 32'h40000000, 32'h80000000, 3'd1, 32'h40000000, 1};
        vecs[8]  = '{3'd5, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 3'd4, 32'h3F800000, 1};
        vecs[9]  = '{3'd0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'd4, 32'h3F800000, 1};
        vecs[10] = '{3'd0, 32'h00000000, 32'hC0000000, 32'hC0000000, 3'd1, 32'hC0000000, 1};
        vecs[11] = '{3'd1, 32'h3F800000, 32'h00000000, 32'h3F800000, 3'd1, 32'h80000000, 1};
        vecs[12] = '{3'd1, 32'h80000000, 32'h00000000, 32'h80000000, 3'd1, 32'h80000000, 1};
        vecs[13] = '{3'd3, 32'h00000000, 32'h40000000, 32'h00000000, 3'd1, 32'h40000000, 1};
        vecs[14] = '{3'd3, 32'h40C00000, 32'h40000000, 32'h40400001, 3'd0, 32'h40000000, 7};
        vecs[15] = '{3'd4, 32'h80000000, 32'h00000000, 32'h80000000, 3'd1, 32'h00000000, 1};
        vecs[16] = '{3'd0, 32'h00000001, 32'h3F800000, 32'h3F800000, 3'd1, 32'h3F800000, 1};
        vecs[17] = '{3'd4, 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'd4, 32'h00000000, 1};
        vecs[18] = '{3'd1, 32'h40000000, 32'h3F800000, 32'h40400000, 3'd0, 32'hBF800000, 2};
        vecs[19] = '{3'd0, 32'h3F800000, 32'hBF800000, 32'h00000000, 3'd1, 32'hBF800000, 1};
        vecs[20] = '{3'd3, 32'h3F800000, 32'hFF800000, 32'h7FC00000, 3'd4, 32'hFF800000, 1};
        vecs[21] = '{3'd2, 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'd4, 32'h00000000, 1};

        // Reset state while rst is held high
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fpu_a", fpu_a, 32'h0);
        check("rst_fpu_b", fpu_b, 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_rd", 32'(resp_rd), 32'd0);
        check("rst_resp_flags", 32'(resp_flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("req_ready_after_rst", 32'(req_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) do_op(vecs[i], 5'(i + 1), 0);

        // Backpressure in DONE, then a back-to-back request
        do_op(vecs[0], 5'd29, 5);
        do_op(vecs[6], 5'd30, 0);

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_a = 32'h3F800000; req_b = 32'h3F800000;
        #1 check("flush_idle_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("flush_idle_busy", 32'(busy), 32'd0);
        flush = 1'b0; req_valid = 1'b0;
        check("flush_idle_no_resp", 32'(resp_valid), 32'd0);

        // Flush a div in EXEC at cnt = 3
        start_div(5'd9);
        @(negedge clk);
        @(negedge clk);
        check("flush_exec_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_exec_busy", 32'(busy), 32'd0);
        watch_no_resp("flush_exec_no_resp");
        do_op(vecs[14], 5'd10, 0);

        // Asynchronous reset in the middle of EXEC
        start_div(5'd12);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_req_ready", 32'(req_ready), 32'd0);
        check("rst_exec_fpu_a", fpu_a, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        watch_no_resp("rst_exec_no_resp");
        do_op(vecs[5], 5'd11, 0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_op_sequencer.md
# fpu_op_sequencer

Multicycle issue controller for the single-precision FPU datapath (adder, multiplier, divider, square root). It accepts one FP operation at a time from the pipeline's execute stage through a valid/ready handshake, and holds registered operands stable on the shared unit inputs for a per-operation latency. It then captures the selected unit's result and returns it with a destination tag through a second valid/ready handshake. Special operands that the datapath does not handle are detected and resolved locally without starting the datapath: zero, denormal (treated as zero), Inf/NaN, exact cancellation, negative sqrt.

## Interface
Parameters:
- ADD_LAT, 1, hold cycles for add/sub (≥1)
- MUL_LAT, 2, hold cycles for mul (≥1)
- DIV_LAT, 6, hold cycles for div (≥1)
- SQRT_LAT, 12, hold cycles for sqrt (≥1)

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  abandon the in-flight op, no response
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle
- req_op  in  3  0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5–7 illegal
- req_a, req_b  in  32  IEEE-754 single operands (req_b ignored for sqrt)
- req_rd  in  5  destination tag
- fpu_a, fpu_b  out  32  registered operands to all units
- add_res, mul_res, div_res, sqrt_res  in  32  unit results
- resp_valid  out  1  result present
- resp_ready  in  1  consumer accepts
- resp_data  out  32  result
- resp_rd  out  5  tag of result
- resp_flags  out  3  {invalid, divzero, bypassed}
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, DONE.
- req_ready = (state==IDLE) & ~flush & ~rst.
- IDLE, on acceptance:
  - latch op, tag, fpu_a=req_a, fpu_b=req_b (sub: fpu_b sign bit inverted; sqrt: fpu_b=0).
  - If bypass applies: load resp_data/resp_flags, go to DONE.
  - Else: cnt=LAT(op)−1, go to EXEC.
- EXEC: if cnt==0, capture the result (add_res for add/sub, mul_res, div_res, sqrt_res) into resp_data, flags=000, go to DONE; else cnt−−.
- DONE: resp_valid=1. On resp_ready, go to IDLE. No new request is accepted in DONE.
- Bypass classification (zero = exponent 0; special = exponent 255), first match wins:
  - Illegal op or any used operand special → 0x7FC00000, flags 100.
  - add/sub: both zero → {sa&sb', 31'b0}; a zero → b'; b zero → a; sa≠sb' with equal magnitudes → 0x00000000. Here b' is b after the sub sign flip.
  - mul: either zero → {sa^sb, 31'b0}.
  - div: both zero → 0x7FC00000, flags 100; b zero → {sa^sb, 8'hFF, 23'b0}, flags 011; a zero → {sa^sb, 31'b0}.
  - sqrt: a zero → a; sa=1 → 0x7FC00000, flags 100.
  - Every other bypass result uses flags 001.
- flush in EXEC or DONE → IDLE next edge, resp_valid low. A simultaneous resp_valid & resp_ready in DONE still counts as a transfer.
- flush in IDLE blocks acceptance.
- fpu_a/fpu_b change only at acceptance.

## Timing
- The acceptance cycle is cycle 0.
  - Datapath op: resp_valid first high in cycle LAT+1.
  - Bypass: resp_valid first high in cycle 1.
- resp_data, resp_rd and resp_flags are stable while resp_valid is high and resp_ready is low.
- After a response handshake in cycle k, req_ready is high in cycle k+1. Back-to-back throughput is one op per LAT+2 cycles.
- Reset (asynchronous, any state): state IDLE, cnt 0, fpu_a/fpu_b 0, resp_valid 0, resp_data 0, resp_rd 0, resp_flags 0, busy 0, req_ready 0 while rst is high. An in-flight op is lost.
- cnt is 4 bits wide; a latency parameter above 16 is rejected at elaboration.

## Structure
- Package fpu_ctrl_pkg holds:
  - op encoding enum
  - FSM state enum
  - QNAN = 32'h7FC00000
  - flag bit indices
  - latency-select function
- Sub-module fpu_special_detect: combinational classifier taking (op, a, b') and producing {hit, result, flags}. It is instantiated once in the sequencer.

## Test plan
- add 0x3F800000 + 0x40000000, ADD_LAT=1, stub add_res=0x40400000 → resp_valid in cycle 2, data 0x40400000, flags 000, rd echoed.
- sub 0x40400000 − 0x40400000 → bypass, cycle 1, data 0x00000000, flags 001, fpu_b sign inverted to 0xC0400000.
- div 0x3F800000 / 0x80000000 → data 0xFF800000, flags 011; div 0/0 → 0x7FC00000, flags 100.
- sqrt 0xC0800000 → 0x7FC00000, flags 100; sqrt 0x40800000 with stub 0x40000000 → resp in cycle 13; fpu_a held 12 cycles.
- Hold resp_ready low 5 cycles in DONE → outputs stable, req_ready low; release → IDLE next cycle, new request accepted.
- flush at EXEC cnt=3 of a div, and separately rst asserted mid-EXEC → no response ever, busy 0 next cycle (immediately for rst), next request completes normally.
